fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one synchronous FIFO write port among N_REQ requesters.

---
 rtl/fifo_wr_arbiter_if.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the round-robin FIFO write arbiter.
// master is the arbiter's view; slave is the view of the blocks around it.
interface fifo_wr_arbiter_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned GRANT_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*FIFO_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_wr_en;
  logic [FIFO_WIDTH-1:0]       fifo_data_in;
  logic                        fifo_full;
  logic                        fifo_wr_ack;
  logic                        fifo_overflow;
  logic [GRANT_W-1:0]          grant_id;
  logic                        busy;
  logic [7:0]                  retry_cnt;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, retry_cnt
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, retry_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters.
// One word per grant: issue, check ack, retry on overflow, then release the requester.
module fifo_wr_arbiter #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned N_REQ      = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int unsigned GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [GRANT_W-1:0] LAST_ID = GRANT_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    RETRY = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic [GRANT_W-1:0]      rr_ptr;
  logic [GRANT_W-1:0]      rr_ptr_next;
  logic [GRANT_W-1:0]      grant_q;
  logic [GRANT_W-1:0]      grant_next;
  logic [FIFO_WIDTH-1:0]   data_q;
  logic [FIFO_WIDTH-1:0]   data_next;
  logic                    wr_en_q;
  logic                    wr_en_next;
  logic [N_REQ-1:0]        ready_q;
  logic [N_REQ-1:0]        ready_next;
  logic                    busy_q;
  logic                    busy_next;
  logic [7:0]              retry_q;
  logic [7:0]              retry_next;

  logic [FIFO_WIDTH-1:0]   words [N_REQ];
  logic                    pick_valid;
  logic [GRANT_W-1:0]      pick_id;
  logic [GRANT_W-1:0]      cand;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_word
    assign words[gi] = bus.req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = GRANT_W'((32'(rr_ptr) + k) % N_REQ);
      if (!pick_valid && bus.req_valid[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A missing ack is treated exactly like an overflow: the word is reissued.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pick_valid && !bus.fifo_full) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (bus.fifo_wr_ack)        state_next = DONE;
        else if (bus.fifo_overflow) state_next = RETRY;
        else                        state_next = RETRY;
      end
      DONE:    state_next = IDLE;
      RETRY:   if (!bus.fifo_full) state_next = ISSUE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition being taken.
  always_comb begin
    grant_next  = grant_q;
    data_next   = data_q;
    rr_ptr_next = rr_ptr;
    retry_next  = retry_q;
    ready_next  = '0;
    wr_en_next  = (state_next == ISSUE);
    busy_next   = (state_next != IDLE);
    if (state == IDLE && state_next == ISSUE) begin
      grant_next = pick_id;
      data_next  = words[pick_id];
    end
    if (state == WAIT && state_next == RETRY && retry_q != 8'hFF) begin
      retry_next = retry_q + 8'd1;
    end
    if (state_next == DONE) begin
      ready_next[grant_q] = 1'b1;
    end
    if (state == DONE) begin
      rr_ptr_next = (grant_q == LAST_ID) ? '0 : grant_q + GRANT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      ready_q <= '0;
      busy_q  <= 1'b0;
      retry_q <= '0;
    end else begin
      rr_ptr  <= rr_ptr_next;
      grant_q <= grant_next;
      data_q  <= data_next;
      wr_en_q <= wr_en_next;
      ready_q <= ready_next;
      busy_q  <= busy_next;
      retry_q <= retry_next;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = busy_q;
  assign bus.retry_cnt    = retry_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a queue-based FIFO and a round-robin reference model.
// Also exercises a single-requester instance.
module tb_fifo_wr_arbiter;
  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned GW = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .N_REQ(N)) bus ();
  fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .N_REQ(1)) bus1 ();

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .N_REQ(N)) dut  (.clk(clk), .rst(rst), .bus(bus));
  fifo_wr_arbiter #(.FIFO_WIDTH(W), .N_REQ(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Words presented by each requester.
  logic [W-1:0] words [N];
  for (genvar g = 0; g < N; g++) begin : g_data
    assign bus.req_data[g*W +: W] = words[g];
  end

  // FIFO model: depth 8, registered ack/overflow, with injectable overflow and silent drops.
  logic [W-1:0] fifo_q[$];
  int fcount = 0;
  int rd_cnt = 0, rd_done = 0, clr_cnt = 0, clr_done = 0, fill_cnt = 0, fill_done = 0;
  int ovf_cnt = 0, ovf_done = 0, nack_cnt = 0, nack_done = 0;
  assign bus.fifo_full = (fcount >= DEPTH);

  always @(posedge clk) begin
    bus.fifo_wr_ack   <= 1'b0;
    bus.fifo_overflow <= 1'b0;
    if (clr_done != clr_cnt) begin
      fifo_q.delete();
      clr_done = clr_cnt;
    end else begin
      if (fill_done != fill_cnt) begin
        while (fifo_q.size() < DEPTH) fifo_q.push_back(W'($urandom));
        fill_done = fill_cnt;
      end else if (bus.fifo_wr_en === 1'b1) begin
        if (ovf_done != ovf_cnt) begin
          bus.fifo_overflow <= 1'b1;
          ovf_done++;
        end else if (nack_done != nack_cnt) begin
          nack_done++;
        end else if (fifo_q.size() >= DEPTH) begin
          bus.fifo_overflow <= 1'b1;
        end else begin
          fifo_q.push_back(bus.fifo_data_in);
          bus.fifo_wr_ack <= 1'b1;
        end
      end
      if (rd_done != rd_cnt) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        rd_done = rd_cnt;
      end
    end
    fcount <= fifo_q.size();
  end

  // Single-requester instance sees an always-accepting FIFO.
  assign bus1.fifo_full     = 1'b0;
  assign bus1.fifo_overflow = 1'b0;
  always @(posedge clk) bus1.fifo_wr_ack <= bus1.fifo_wr_en;

  int checks = 0, errors = 0;
  int rr_m = 0, retry_m = 0;
  logic [W-1:0] exp_q[$];

  int           o_gid, o_n_wr, o_wr_lat, o_lat;
  logic [W-1:0] o_wdata;
  logic [N-1:0] o_rdy;
  bit           o_same;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < int'(N); k++) begin
      int i;
      i = (ptr + k) % int'(N);
      if (v[GW'(i)]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return (i < 0) ? '0 : (N'(1) << i);
  endfunction

  // Follows one transaction to its req_ready pulse, acting as the requester on release.
  task automatic observe(input int budget, input bit refill, input bit scramble, input bit drop);
    bit fin;
    o_gid = -1; o_wdata = '0; o_rdy = '0; o_n_wr = 0; o_wr_lat = -1; o_lat = -1; o_same = 1'b1;
    fin = 1'b0;
    for (int k = 1; k <= budget && !fin; k++) begin
      @(negedge clk);
      if (bus.fifo_wr_en === 1'b1) begin
        if (o_n_wr == 0) begin
          o_wr_lat = k;
          o_wdata  = bus.fifo_data_in;
          o_gid    = int'(bus.grant_id);
          if (scramble) words[GW'(o_gid)] = ~o_wdata;
          if (drop) bus.req_valid[GW'(o_gid)] = 1'b0;
        end else if (bus.fifo_data_in !== o_wdata || int'(bus.grant_id) != o_gid) begin
          o_same = 1'b0;
        end
        o_n_wr++;
      end
      if (bus.req_ready !== '0) begin
        o_rdy = bus.req_ready;
        o_lat = k;
        fin   = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
          if (o_rdy[GW'(i)]) begin
            bus.req_valid[GW'(i)] = refill;
            if (refill) words[GW'(i)] = W'($urandom);
          end
        end
      end
    end
  endtask

  task automatic settle();
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_fifo();
    clr_cnt++;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    retry_m = 0;
  endtask

  task automatic check_fifo(input string name);
    bit ok;
    ok = (fifo_q.size() == exp_q.size());
    if (ok) foreach (exp_q[i]) if (fifo_q[i] !== exp_q[i]) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL %s fifo contents: got %0d words, want %0d", name, fifo_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus1.req_valid = '0;
    bus1.req_data = '0;
    for (int i = 0; i < int'(N); i++) words[GW'(i)] = '0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.fifo_wr_en, bus.req_ready, bus.busy} !== '0) begin errors++; $display("FAIL reset_ctrl got %b want 0", {bus.fifo_wr_en, bus.req_ready, bus.busy}); end
    checks++; if ({bus.grant_id, bus.retry_cnt, bus.fifo_data_in} !== '0) begin errors++; $display("FAIL reset_data got %h want 0", {bus.grant_id, bus.retry_cnt, bus.fifo_data_in}); end
    checks++; if ({bus1.busy, bus1.req_ready, bus1.grant_id} !== '0) begin errors++; $display("FAIL reset_n1 got %b want 0", {bus1.busy, bus1.req_ready, bus1.grant_id}); end
    rst = 1'b0;
    rr_m = 0;
    retry_m = 0;
    clear_fifo();
  endtask

  task automatic test_single();
    words[0] = 16'h1234;
    bus.req_valid = 4'b0001;
    observe(20, 1'b0, 1'b0, 1'b0);
    checks++; if (o_wr_lat != 1) begin errors++; $display("FAIL single_wr_lat got %0d want 1", o_wr_lat); end
    checks++; if (o_wdata !== 16'h1234) begin errors++; $display("FAIL single_data got %h want 1234", o_wdata); end
    checks++; if (o_lat != 3 || o_rdy !== 4'b0001) begin errors++; $display("FAIL single_ready got %b at %0d want 0001 at 3", o_rdy, o_lat); end
    checks++; if (o_gid != 0 || o_n_wr != 1) begin errors++; $display("FAIL single_grant got id %0d writes %0d want 0 1", o_gid, o_n_wr); end
    exp_q.push_back(16'h1234);
    rr_m = 1;
    settle();
    check_fifo("single");
  endtask

  // All four requesters kept busy: grant rotation and 4-cycle back-to-back spacing.
  task automatic test_fairness();
    int eg;
    logic [W-1:0] ew;
    settle();
    apply_reset();
    clear_fifo();
    for (int i = 0; i < int'(N); i++) words[GW'(i)] = W'(i);
    bus.req_valid = 4'b1111;
    for (int it = 0; it < 8; it++) begin
      eg = pick(bus.req_valid, rr_m);
      ew = words[GW'(eg)];
      observe(20, 1'b1, 1'b0, 1'b0);
      checks++; if (o_gid != eg || o_rdy !== onehot(eg)) begin errors++; $display("FAIL fair_grant it %0d got %0d/%b want %0d", it, o_gid, o_rdy, eg); end
      checks++; if (o_wdata !== ew) begin errors++; $display("FAIL fair_data it %0d got %h want %h", it, o_wdata, ew); end
      checks++; if (o_wr_lat != ((it == 0) ? 1 : 2) || o_lat != ((it == 0) ? 3 : 4)) begin errors++; $display("FAIL fair_timing it %0d got %0d/%0d", it, o_wr_lat, o_lat); end
      exp_q.push_back(ew);
      rr_m = (eg + 1) % int'(N);
    end
    settle();
    check_fifo("fair");
  endtask

  task automatic test_wrap();
    settle();
    clear_fifo();
    words[1] = W'($urandom);
    bus.req_valid = 4'b0010;
    observe(20, 1'b0, 1'b0, 1'b0);
    checks++; if (o_gid != 1) begin errors++; $display("FAIL wrap_first got %0d want 1", o_gid); end
    rr_m = 2;
    words[0] = W'($urandom);
    words[3] = W'($urandom);
    bus.req_valid = 4'b1001;
    observe(20, 1'b0, 1'b0, 1'b0);
    checks++; if (o_gid != 3 || o_rdy !== 4'b1000) begin errors++; $display("FAIL wrap_second got %0d/%b want 3", o_gid, o_rdy); end
    observe(20, 1'b0, 1'b0, 1'b0);
    checks++; if (o_gid != 0 || o_rdy !== 4'b0001) begin errors++; $display("FAIL wrap_third got %0d/%b want 0", o_gid, o_rdy); end
    rr_m = 1;
  endtask

  task automatic test_full();
    int act;
    logic [W-1:0] ew;
    settle();
    clear_fifo();
    fill_cnt++;
    @(negedge clk);
    words[2] = W'($urandom);
    ew = words[2];
    bus.req_valid = 4'b0100;
    act = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.fifo_wr_en !== 1'b0 || bus.busy !== 1'b0) act++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL full_hold got %0d active cycles want 0", act); end
    rd_cnt++;
    observe(20, 1'b0, 1'b0, 1'b0);
    checks++; if (o_wr_lat != 2 || o_lat != 4) begin errors++; $display("FAIL full_timing got %0d/%0d want 2/4", o_wr_lat, o_lat); end
    checks++; if (o_gid != 2 || o_wdata !== ew) begin errors++; $display("FAIL full_word got %0d/%h want 2/%h", o_gid, o_wdata, ew); end
    checks++; if (fifo_q.size() != DEPTH || fifo_q[DEPTH-1] !== ew) begin errors++; $display("FAIL full_fifo got size %0d want %0d", fifo_q.size(), DEPTH); end
    rr_m = 3;
  endtask

  // Overflow, then a missing ack: each costs one reissue of the latched word.
  task automatic test_overflow();
    int eg;
    logic [W-1:0] ew;
    settle();
    clear_fifo();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < int'(N); i++) words[GW'(i)] = W'($urandom);
      bus.req_valid = N'($urandom_range(1, 15));
      eg = pick(bus.req_valid, rr_m);
      ew = words[GW'(eg)];
      if (m == 0) ovf_cnt++; else nack_cnt++;
      observe(40, 1'b0, 1'b0, 1'b0);
      retry_m = (retry_m < 255) ? retry_m + 1 : 255;
      checks++; if (o_n_wr != 2 || !o_same) begin errors++; $display("FAIL retry_reissue m %0d got %0d writes same %0d want 2 1", m, o_n_wr, o_same); end
      checks++; if (o_lat != 6 || o_rdy !== onehot(eg)) begin errors++; $display("FAIL retry_ready m %0d got %b at %0d want %b at 6", m, o_rdy, o_lat, onehot(eg)); end
      checks++; if (o_wdata !== ew) begin errors++; $display("FAIL retry_data m %0d got %h want %h", m, o_wdata, ew); end
      checks++; if (int'(bus.retry_cnt) != retry_m) begin errors++; $display("FAIL retry_cnt m %0d got %0d want %0d", m, bus.retry_cnt, retry_m); end
      exp_q.push_back(ew);
      rr_m = (eg + 1) % int'(N);
      settle();
    end
    check_fifo("retry");
    words[0] = W'($urandom);
    words[1] = W'($urandom);
    bus.req_valid = 4'b0011;
    eg = pick(bus.req_valid, rr_m);
    observe(20, 1'b0, 1'b0, 1'b0);
    checks++; if (o_gid != eg) begin errors++; $display("FAIL retry_rr got %0d want %0d", o_gid, eg); end
    rr_m = (eg + 1) % int'(N);
  endtask

  task automatic test_saturate();
    settle();
    apply_reset();
    clear_fifo();
    words[0] = W'($urandom);
    bus.req_valid = 4'b0001;
    ovf_cnt += 260;
    observe(1200, 1'b0, 1'b0, 1'b0);
    retry_m = 255;
    checks++; if (int'(bus.retry_cnt) != retry_m) begin errors++; $display("FAIL sat_cnt got %0d want 255", bus.retry_cnt); end
    checks++; if (o_n_wr != 261 || o_rdy !== 4'b0001) begin errors++; $display("FAIL sat_writes got %0d/%b want 261/0001", o_n_wr, o_rdy); end
    rr_m = 1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [W-1:0] ew;
    settle();
    clear_fifo();
    words[2] = W'($urandom);
    bus.req_valid = 4'b0100;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      seen = (bus.fifo_wr_en === 1'b1);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_issue got no fifo_wr_en want one"); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b want 1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.fifo_wr_en, bus.req_ready, bus.busy, bus.grant_id, bus.retry_cnt, bus.fifo_data_in} !== '0) begin errors++; $display("FAIL rmid_outputs got %h want 0", {bus.fifo_wr_en, bus.req_ready, bus.busy, bus.grant_id, bus.retry_cnt, bus.fifo_data_in}); end
    rst = 1'b0;
    rr_m = 0;
    retry_m = 0;
    words[0] = W'($urandom);
    ew = words[0];
    bus.req_valid = 4'b0101;
    observe(20, 1'b0, 1'b0, 1'b0);
    checks++; if (o_gid != 0 || o_rdy !== 4'b0001 || o_wr_lat != 1) begin errors++; $display("FAIL rmid_next got %0d/%b/%0d want 0/0001/1", o_gid, o_rdy, o_wr_lat); end
    checks++; if (o_wdata !== ew) begin errors++; $display("FAIL rmid_data got %h want %h", o_wdata, ew); end
    ew = words[2];
    observe(20, 1'b0, 1'b0, 1'b0);
    checks++; if (o_gid != 2 || o_wdata !== ew) begin errors++; $display("FAIL rmid_after got %0d/%h want 2/%h", o_gid, o_wdata, ew); end
    rr_m = 3;
  endtask

  // Random masks, late data changes, dropped valids and occasional overflow.
  task automatic test_random();
    int eg;
    logic [W-1:0] ew;
    logic [N-1:0] add;
    bit ovf;
    settle();
    clear_fifo();
    for (int it = 0; it < 40; it++) begin
      if (fifo_q.size() >= 6) clear_fifo();
      add = N'($urandom_range(1, 15));
      for (int i = 0; i < int'(N); i++)
        if (add[GW'(i)] && !bus.req_valid[GW'(i)]) words[GW'(i)] = W'($urandom);
      bus.req_valid = bus.req_valid | add;
      ovf = ($urandom_range(0, 3) == 0);
      if (ovf) ovf_cnt++;
      eg = pick(bus.req_valid, rr_m);
      ew = words[GW'(eg)];
      observe(40, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (ovf) retry_m = (retry_m < 255) ? retry_m + 1 : 255;
      checks++; if (o_gid != eg || o_rdy !== onehot(eg)) begin errors++; $display("FAIL rand_grant it %0d got %0d/%b want %0d", it, o_gid, o_rdy, eg); end
      checks++; if (o_wdata !== ew || !o_same) begin errors++; $display("FAIL rand_data it %0d got %h want %h", it, o_wdata, ew); end
      checks++; if (o_n_wr != (ovf ? 2 : 1) || int'(bus.retry_cnt) != retry_m) begin errors++; $display("FAIL rand_retry it %0d got %0d writes cnt %0d want cnt %0d", it, o_n_wr, bus.retry_cnt, retry_m); end
      exp_q.push_back(ew);
      rr_m = (eg + 1) % int'(N);
    end
    settle();
    check_fifo("rand");
  endtask

  task automatic test_single_requester();
    logic [W-1:0] d, seen_d;
    int got, nwr;
    for (int t = 0; t < 2; t++) begin
      d = W'($urandom);
      seen_d = '0;
      got = -1;
      nwr = 0;
      bus1.req_data = d;
      bus1.req_valid = 1'b1;
      for (int k = 1; k <= 12 && got < 0; k++) begin
        @(negedge clk);
        if (bus1.fifo_wr_en === 1'b1) begin
          nwr++;
          seen_d = bus1.fifo_data_in;
        end
        if (bus1.req_ready === 1'b1) begin
          got = k;
          bus1.req_valid = 1'b0;
          checks++; if (bus1.grant_id !== 1'b0) begin errors++; $display("FAIL n1_grant t %0d got %b want 0", t, bus1.grant_id); end
        end
      end
      checks++; if (got != ((t == 0) ? 3 : 4) || nwr != 1) begin errors++; $display("FAIL n1_timing t %0d got %0d writes %0d", t, got, nwr); end
      checks++; if (seen_d !== d) begin errors++; $display("FAIL n1_data t %0d got %h want %h", t, seen_d, d); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_full();
    test_overflow();
    test_saturate();
    test_reset_mid();
    test_random();
    test_single_requester();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
